// File: rtl/lc3b_types.sv
// lc3b_types: shared memory-hierarchy types (cache line, L2 arbiter state and owner encodings)
package lc3b_types;
  typedef logic [127:0] lc3b_c_line;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2,
    S_RELEASE = 2'd3
  } l2_arb_state_t;
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } l2_arb_owner_t;
endpackage

// File: rtl/l2_arb_pick.sv
// l2_arb_pick: I/D winner selection; D wins ties unless L2_ARB_ROUND_ROBIN_EN alternates them
module l2_arb_pick (
  input  logic i_act,
  input  logic d_act,
`ifdef L2_ARB_ROUND_ROBIN_EN
  input  logic last_d,
`endif
  output logic pick_d
);
`ifdef L2_ARB_ROUND_ROBIN_EN
  assign pick_d = d_act && (!i_act || !last_d);
`else
  assign pick_d = d_act;
`endif
endmodule

// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter: shares the L2 port between I/D miss paths; optional L2_ARB_ROUND_ROBIN_EN tie rotation
module l2_mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_address,
  input  logic [LINE_W-1:0] i_mem_wdata,
  output logic              i_mem_resp,
  output logic [LINE_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic              d_mem_resp,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              l2_mem_read,
  output logic              l2_mem_write,
  output logic [ADDR_W-1:0] l2_mem_address,
  output logic [LINE_W-1:0] l2_mem_wdata,
  input  logic              l2_mem_resp,
  input  logic [LINE_W-1:0] l2_mem_rdata,
  output logic [1:0]        owner
);
  l2_arb_state_t state, state_n;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              i_act, d_act, pick_d, take;
  l2_arb_owner_t     own;
  assign i_act = i_mem_read || i_mem_write;
  assign d_act = d_mem_read || d_mem_write;
  assign take  = (state == S_IDLE) && (i_act || d_act);
`ifdef L2_ARB_ROUND_ROBIN_EN
  logic last_d;
`endif
  l2_arb_pick u_pick (
    .i_act  (i_act),
    .d_act  (d_act),
`ifdef L2_ARB_ROUND_ROBIN_EN
    .last_d (last_d),
`endif
    .pick_d (pick_d)
  );
  // state register; reset abandons any in-flight L2 transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  end
  // capture the winner's transaction once, so it stays stable for the whole grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      op_wr   <= pick_d ? d_mem_write : i_mem_write;
      addr_q  <= pick_d ? d_mem_address : i_mem_address;
      wdata_q <= pick_d ? d_mem_wdata : i_mem_wdata;
    end
  end
`ifdef L2_ARB_ROUND_ROBIN_EN
  // remember who completed last so the next tie goes to the other side (reset: I)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_d <= 1'b0;
    else if (l2_mem_resp && (state == S_GRANT_I || state == S_GRANT_D)) last_d <= (state == S_GRANT_D);
  end
`endif
  // next state and L2/requester outputs; everything is gated by the grant so RELEASE and IDLE drive zeros
  always_comb begin
    state_n        = state;
    own            = OWN_NONE;
    l2_mem_read    = 1'b0;
    l2_mem_write   = 1'b0;
    l2_mem_address = '0;
    l2_mem_wdata   = '0;
    unique case (state)
      S_IDLE:    state_n = take ? (pick_d ? S_GRANT_D : S_GRANT_I) : S_IDLE;
      S_GRANT_I: state_n = l2_mem_resp ? S_RELEASE : S_GRANT_I;
      S_GRANT_D: state_n = l2_mem_resp ? S_RELEASE : S_GRANT_D;
      default:   state_n = S_IDLE;
    endcase
    own = (state == S_GRANT_I) ? OWN_I : (state == S_GRANT_D) ? OWN_D : OWN_NONE;
    if (own != OWN_NONE) begin
      l2_mem_read    = !op_wr;
      l2_mem_write   = op_wr;
      l2_mem_address = addr_q;
      l2_mem_wdata   = wdata_q;
    end
  end
  assign owner       = own;
  assign i_mem_resp  = l2_mem_resp && (state == S_GRANT_I);
  assign d_mem_resp  = l2_mem_resp && (state == S_GRANT_D);
  assign i_mem_rdata = (state == S_GRANT_I) ? l2_mem_rdata : '0;
  assign d_mem_rdata = (state == S_GRANT_D) ? l2_mem_rdata : '0;
endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb_l2_mem_arbiter: table vectors, corner sequences and a randomized run against a transaction-level model
module tb_l2_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_mem_read = 0, i_mem_write = 0, d_mem_read = 0, d_mem_write = 0;
  logic [15:0]  i_mem_address = 0, d_mem_address = 0;
  logic [127:0] i_mem_wdata = 0, d_mem_wdata = 0;
  logic         i_mem_resp, d_mem_resp;
  logic [127:0] i_mem_rdata, d_mem_rdata;
  logic         l2_mem_read, l2_mem_write;
  logic [15:0]  l2_mem_address;
  logic [127:0] l2_mem_wdata;
  logic         l2_mem_resp = 0;
  logic [127:0] l2_mem_rdata = 0;
  logic [1:0]   owner;
  int n_chk = 0, n_err = 0;

  localparam logic [127:0] LINE_A = {16{8'hAA}};
  localparam logic [127:0] LINE_5 = {16{8'h55}};
  localparam logic [127:0] LINE_3 = {16{8'h33}};

  l2_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_address(i_mem_address),
    .i_mem_wdata(i_mem_wdata), .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address),
    .d_mem_wdata(d_mem_wdata), .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
    .l2_mem_read(l2_mem_read), .l2_mem_write(l2_mem_write), .l2_mem_address(l2_mem_address),
    .l2_mem_wdata(l2_mem_wdata), .l2_mem_resp(l2_mem_resp), .l2_mem_rdata(l2_mem_rdata),
    .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // transaction-level reference: who holds the port, what was captured, whether a release cycle is due
  int           m_own;
  bit           m_rel, m_last_d, m_wr;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;

  function automatic bit d_wins(bit ia, bit da, bit last_d);
`ifdef L2_ARB_ROUND_ROBIN_EN
    return da && (!ia || !last_d);
`else
    return da;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own <= 0; m_rel <= 0; m_last_d <= 0; m_wr <= 0; m_addr <= 0; m_wdata <= 0;
    end else if (m_own != 0) begin
      if (l2_mem_resp) begin
        m_last_d <= (m_own == 2);
        m_own <= 0;
        m_rel <= 1;
      end
    end else if (m_rel) begin
      m_rel <= 0;
    end else if (i_mem_read || i_mem_write || d_mem_read || d_mem_write) begin
      if (d_wins(i_mem_read || i_mem_write, d_mem_read || d_mem_write, m_last_d)) begin
        m_own <= 2; m_wr <= d_mem_write; m_addr <= d_mem_address; m_wdata <= d_mem_wdata;
      end else begin
        m_own <= 1; m_wr <= i_mem_write; m_addr <= i_mem_address; m_wdata <= i_mem_wdata;
      end
    end
  end

  task automatic chk_model(input string tag);
    chk({tag, " owner"}, 128'(owner), 128'(m_own));
    chk({tag, " l2_read"}, 128'(l2_mem_read), 128'(m_own != 0 && !m_wr));
    chk({tag, " l2_write"}, 128'(l2_mem_write), 128'(m_own != 0 && m_wr));
    chk({tag, " l2_addr"}, 128'(l2_mem_address), (m_own != 0) ? 128'(m_addr) : 128'(0));
    chk({tag, " l2_wdata"}, l2_mem_wdata, (m_own != 0) ? m_wdata : 128'(0));
    chk({tag, " i_resp"}, 128'(i_mem_resp), 128'(m_own == 1 && l2_mem_resp));
    chk({tag, " d_resp"}, 128'(d_mem_resp), 128'(m_own == 2 && l2_mem_resp));
    chk({tag, " i_rdata"}, i_mem_rdata, (m_own == 1) ? l2_mem_rdata : 128'(0));
    chk({tag, " d_rdata"}, d_mem_rdata, (m_own == 2) ? l2_mem_rdata : 128'(0));
  endtask

  typedef struct {
    bit ir, iw, dr, dw;
    logic [15:0] ia, da;
    bit resp;
    logic [1:0] eo;
    bit er, ew;
    logic [15:0] ea;
  } vec_t;
  vec_t tv[19];

  task automatic wait_owner(input string nm, input logic [1:0] exp, output int cyc);
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cyc++;
      if (owner != 2'b00) break;
    end
    chk(nm, 128'(owner), 128'(exp));
  endtask

  task automatic do_resp(input string nm, input logic [1:0] who);
    @(posedge clk); #1 l2_mem_resp = 1;
    @(negedge clk);
    chk({nm, " i_resp"}, 128'(i_mem_resp), 128'(who == 2'b01));
    chk({nm, " d_resp"}, 128'(d_mem_resp), 128'(who == 2'b10));
    @(posedge clk); #1 l2_mem_resp = 0;
  endtask

  initial begin
    int cyc;
    //            ir iw dr dw ia        da        resp eo     er ew ea
    tv[0]  = '{1, 0, 0, 0, 16'h1230, 16'h0000, 0, 2'b00, 0, 0, 16'h0000};
    tv[1]  = '{1, 0, 0, 0, 16'h1230, 16'h0000, 0, 2'b01, 1, 0, 16'h1230};
    tv[2]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 2'b01, 1, 0, 16'h1230};
    tv[3]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 2'b01, 1, 0, 16'h1230};
    tv[4]  = '{0, 0, 0, 1, 16'h0000, 16'h0040, 0, 2'b00, 0, 0, 16'h0000};
    tv[5]  = '{0, 0, 0, 1, 16'h0000, 16'h0040, 0, 2'b00, 0, 0, 16'h0000};
    tv[6]  = '{0, 0, 0, 1, 16'h0000, 16'h0040, 0, 2'b10, 0, 1, 16'h0040};
    tv[7]  = '{0, 0, 0, 1, 16'h0000, 16'h0080, 0, 2'b10, 0, 1, 16'h0040};
    tv[8]  = '{0, 0, 0, 1, 16'h0000, 16'h0080, 1, 2'b10, 0, 1, 16'h0040};
    tv[9]  = '{1, 0, 0, 1, 16'h0010, 16'h0020, 0, 2'b00, 0, 0, 16'h0000};
    tv[10] = '{1, 0, 0, 1, 16'h0010, 16'h0020, 1, 2'b00, 0, 0, 16'h0000};
    tv[11] = '{1, 0, 0, 1, 16'h0010, 16'h0020, 0, 2'b10, 0, 1, 16'h0020};
    tv[12] = '{1, 0, 0, 0, 16'h0010, 16'h0000, 1, 2'b10, 0, 1, 16'h0020};
    tv[13] = '{1, 0, 0, 0, 16'h0010, 16'h0000, 0, 2'b00, 0, 0, 16'h0000};
    tv[14] = '{1, 0, 0, 0, 16'h0010, 16'h0000, 0, 2'b00, 0, 0, 16'h0000};
    tv[15] = '{1, 0, 0, 0, 16'h0010, 16'h0000, 0, 2'b01, 1, 0, 16'h0010};
    tv[16] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 2'b01, 1, 0, 16'h0010};
    tv[17] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 16'h0000};
    tv[18] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 2'b00, 0, 0, 16'h0000};

    i_mem_wdata = LINE_3;
    d_mem_wdata = LINE_5;
    l2_mem_rdata = LINE_A;
    i_mem_read = 1;
    i_mem_address = 16'h1230;
    repeat (2) @(posedge clk);
    #1;
    chk("rst owner", 128'(owner), 0);
    chk("rst l2_read", 128'(l2_mem_read), 0);
    chk("rst l2_write", 128'(l2_mem_write), 0);
    chk("rst l2_addr", 128'(l2_mem_address), 0);
    chk("rst l2_wdata", l2_mem_wdata, 0);
    chk("rst i_resp", 128'(i_mem_resp), 0);
    chk("rst d_resp", 128'(d_mem_resp), 0);
    chk("rst i_rdata", i_mem_rdata, 0);
    chk("rst d_rdata", d_mem_rdata, 0);
    rst_n = 1;

    for (int k = 0; k < 19; k++) begin
      i_mem_read = tv[k].ir; i_mem_write = tv[k].iw;
      d_mem_read = tv[k].dr; d_mem_write = tv[k].dw;
      i_mem_address = tv[k].ia; d_mem_address = tv[k].da;
      l2_mem_resp = tv[k].resp;
      @(negedge clk);
      chk($sformatf("vec%0d owner", k), 128'(owner), 128'(tv[k].eo));
      chk($sformatf("vec%0d l2_read", k), 128'(l2_mem_read), 128'(tv[k].er));
      chk($sformatf("vec%0d l2_write", k), 128'(l2_mem_write), 128'(tv[k].ew));
      chk($sformatf("vec%0d l2_addr", k), 128'(l2_mem_address), 128'(tv[k].ea));
      chk($sformatf("vec%0d l2_wdata", k), l2_mem_wdata,
          (tv[k].eo == 2'b01) ? LINE_3 : (tv[k].eo == 2'b10) ? LINE_5 : 128'(0));
      chk($sformatf("vec%0d i_resp", k), 128'(i_mem_resp), 128'(tv[k].resp && tv[k].eo == 2'b01));
      chk($sformatf("vec%0d d_resp", k), 128'(d_mem_resp), 128'(tv[k].resp && tv[k].eo == 2'b10));
      chk($sformatf("vec%0d i_rdata", k), i_mem_rdata, (tv[k].eo == 2'b01) ? LINE_A : 128'(0));
      chk($sformatf("vec%0d d_rdata", k), d_mem_rdata, (tv[k].eo == 2'b10) ? LINE_A : 128'(0));
      @(posedge clk); #1;
    end

    // two ties in a row: first to D, second alternates only with rotation enabled
    i_mem_read = 1; i_mem_address = 16'h0100;
    d_mem_read = 1; d_mem_address = 16'h0200;
    wait_owner("tie1 owner", 2'b10, cyc);
    do_resp("tie1", 2'b10);
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cyc++;
      if (owner != 2'b00) break;
    end
`ifdef L2_ARB_ROUND_ROBIN_EN
    chk("tie2 owner", 128'(owner), 128'(2'b01));
    chk("tie2 addr", 128'(l2_mem_address), 128'(16'h0100));
    do_resp("tie2", 2'b01);
`else
    chk("tie2 owner", 128'(owner), 128'(2'b10));
    chk("tie2 addr", 128'(l2_mem_address), 128'(16'h0200));
    do_resp("tie2", 2'b10);
`endif
    chk("turnaround cycles", 128'(cyc), 128'(3));
    i_mem_read = 0; d_mem_read = 0;
    repeat (3) @(posedge clk);
    #1;

    // reset during an I grant, D waiting
    i_mem_read = 1; i_mem_address = 16'h0300;
    wait_owner("rstmid grant", 2'b01, cyc);
    d_mem_write = 1; d_mem_address = 16'h0400;
    #1 rst_n = 0;
    #1;
    chk("rstmid owner", 128'(owner), 0);
    chk("rstmid l2_read", 128'(l2_mem_read), 0);
    chk("rstmid l2_addr", 128'(l2_mem_address), 0);
    chk("rstmid i_rdata", i_mem_rdata, 0);
    @(posedge clk); #1 rst_n = 1; i_mem_read = 0;
    @(negedge clk);
    chk("rstmid idle", 128'(owner), 0);
    @(negedge clk);
    chk("rstmid d granted", 128'(owner), 128'(2'b10));
    chk("rstmid d write", 128'(l2_mem_write), 1);
    chk("rstmid d addr", 128'(l2_mem_address), 128'(16'h0400));
    do_resp("rstmid", 2'b10);
    d_mem_write = 0;
    repeat (3) @(posedge clk);
    #1;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      i_mem_read  = ($urandom_range(0, 2) == 0);
      i_mem_write = ($urandom_range(0, 4) == 0);
      d_mem_read  = ($urandom_range(0, 2) == 0);
      d_mem_write = ($urandom_range(0, 4) == 0);
      i_mem_address = 16'($urandom);
      d_mem_address = 16'($urandom);
      i_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      l2_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      l2_mem_resp = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      chk_model("rand");
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
